bidir_tx_sched: RTL and testbench

- Packet scheduler between the TX FIFO AXI-stream output and the three bidir TX lanes.
- Dispatches whole tlast-delimited packets to one lane at a time.
- Two modes: round-robin over enabled lanes, or fixed-lane.
- Provides per-lane packet counters and a sticky stall flag for CPU status readback via the bidir register block.

---
 rtl/gyro_sched_pkg.sv | 15 +
 rtl/rr_arb_next.sv | 48 ++++
 rtl/bidir_tx_sched.sv | 149 ++++++++++++++
 tb/tb_bidir_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_sched_pkg.sv
// Shared types and defaults for the bidir TX scheduler and the RX merge path.
// No logic, so no latency or backpressure behaviour.
// Used by bidir_tx_sched and rr_arb_next.
package gyro_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

    localparam int CH_IDX_W        = 2;
    localparam int CNT_W_DEF       = 16;
    localparam int STALL_LIMIT_DEF = 1024;

endpackage

// File: rtl/rr_arb_next.sv
// Next-eligible-lane finder: round-robin from last grant + 1, or a single fixed lane.
// Latency: purely combinational.
// Backpressure: none; o_valid=0 when no lane qualifies.
module rr_arb_next
    import gyro_sched_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH-1:0]   i_mask,
    input  logic [CH_IDX_W-1:0] i_last_grant,
    input  logic                i_fixed_en,
    input  logic [CH_IDX_W-1:0] i_fixed_ch,
    output logic                o_valid,
    output logic [CH_IDX_W-1:0] o_idx
);

    logic                w_rr_vld;
    logic [CH_IDX_W-1:0] w_rr_idx;
    logic                w_fx_vld;

    // Scan offsets from farthest to nearest so the nearest enabled lane wins.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_mask[i] && (((int'(i_last_grant) + k) % NUM_CH) == i)) begin
                    w_rr_vld = 1'b1;
                    w_rr_idx = CH_IDX_W'(i);
                end
            end
        end
    end

    // Out-of-range fixed lanes never match a real lane index.
    always_comb begin
        w_fx_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((i_fixed_ch == CH_IDX_W'(i)) && i_mask[i]) begin
                w_fx_vld = 1'b1;
            end
        end
    end

    assign o_valid = i_fixed_en ? w_fx_vld   : w_rr_vld;
    assign o_idx   = i_fixed_en ? i_fixed_ch : w_rr_idx;

endmodule

// File: rtl/bidir_tx_sched.sv
// Packet scheduler steering whole AXI-stream packets from the TX FIFO to one bidir lane.
// Latency: data is combinational pass-through; one arbitration bubble per packet.
// Backpressure: s_tready follows the granted lane's m_tready in XFER, held 0 in IDLE.
module bidir_tx_sched
    import gyro_sched_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_CH-1:0]       cfg_ch_en,
    input  logic                    cfg_fixed_en,
    input  logic [CH_IDX_W-1:0]     cfg_fixed_ch,
    input  logic                    cnt_clr,
    input  logic [DATA_W-1:0]       s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tlast,
    output logic [NUM_CH-1:0]       m_tvalid,
    input  logic [NUM_CH-1:0]       m_tready,
    output logic                    busy,
    output logic [CH_IDX_W-1:0]     cur_ch,
    output logic [NUM_CH*CNT_W-1:0] pkt_cnt,
    output logic                    stall_err
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    sched_state_e        r_state;
    logic [CH_IDX_W-1:0] r_grant;
    logic [CH_IDX_W-1:0] r_last_grant;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_stall_err;
    logic [CNT_W-1:0]    r_pkt_cnt [NUM_CH];

    logic [NUM_CH-1:0]   w_grant_oh;
    logic                w_xfer;
    logic                w_lane_rdy;
    logic                w_hs;
    logic                w_pkt_done;
    logic                w_stalled;
    logic                w_arb_vld;
    logic [CH_IDX_W-1:0] w_arb_idx;

    rr_arb_next #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_mask       (cfg_ch_en),
        .i_last_grant (r_last_grant),
        .i_fixed_en   (cfg_fixed_en),
        .i_fixed_ch   (cfg_fixed_ch),
        .o_valid      (w_arb_vld),
        .o_idx        (w_arb_idx)
    );

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant == CH_IDX_W'(i)) begin
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    assign w_xfer     = (r_state == XFER);
    assign w_lane_rdy = |(m_tready & w_grant_oh);
    assign w_hs       = s_tvalid & s_tready;
    assign w_pkt_done = w_hs & s_tlast;
    assign w_stalled  = w_xfer & s_tvalid & ~w_lane_rdy;

    assign s_tready  = w_xfer & w_lane_rdy;
    assign m_tvalid  = w_grant_oh & {NUM_CH{w_xfer & s_tvalid}};
    assign m_tdata   = s_tdata;
    assign m_tlast   = s_tlast;
    assign busy      = w_xfer;
    assign cur_ch    = r_grant;
    assign stall_err = r_stall_err;

    // Config is only sampled in IDLE, which keeps each packet on one lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= CH_IDX_W'(NUM_CH - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_tvalid && w_arb_vld) begin
                        r_state <= XFER;
                        r_grant <= w_arb_idx;
                    end
                end
                XFER: begin
                    if (w_pkt_done) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counter holds while upstream idles mid-packet; only true backpressure advances it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (cnt_clr || !w_xfer || w_hs) begin
                r_stall_cnt <= '0;
            end else if (w_stalled && (r_stall_cnt != STALL_W'(STALL_LIMIT))) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (cnt_clr) begin
                r_stall_err <= 1'b0;
            end else if (w_stalled && (r_stall_cnt == STALL_W'(STALL_LIMIT - 1))) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clr) begin
                    r_pkt_cnt[i] <= '0;
                end else if (w_pkt_done && w_grant_oh[i]) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
    end

endmodule

// File: tb/tb_bidir_tx_sched.sv
// Scoreboard bench for bidir_tx_sched: beats are queued as driven and popped at lane handshakes.
module tb_bidir_tx_sched;

    localparam int NCH   = 3;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int LIMIT = 16;
    localparam int HS_BUDGET = 200;

    typedef struct packed {
        logic [1:0]    lane;
        logic          last;
        logic [DW-1:0] data;
    } sb_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH-1:0]    cfg_ch_en = '1;
    logic              cfg_fixed_en = 1'b0;
    logic [1:0]        cfg_fixed_ch = '0;
    logic              cnt_clr = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic [NCH-1:0]    m_tvalid;
    logic [NCH-1:0]    m_tready = '1;
    logic              busy;
    logic [1:0]        cur_ch;
    logic [NCH*CW-1:0] pkt_cnt;
    logic              stall_err;

    int      n_chk = 0;
    int      n_pass = 0;
    int      n_push = 0;
    int      n_pop = 0;
    int      cyc = 0;
    int      exp_cnt [NCH];
    int      lane_beats [NCH];
    int      hs_cyc [$];
    sb_t     sb_q [$];
    logic [DW-1:0] seq = 32'h1000_0000;

    bidir_tx_sched #(
        .DATA_W      (DW),
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_ch_en    (cfg_ch_en),
        .cfg_fixed_en (cfg_fixed_en),
        .cfg_fixed_ch (cfg_fixed_ch),
        .cnt_clr      (cnt_clr),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .busy         (busy),
        .cur_ch       (cur_ch),
        .pkt_cnt      (pkt_cnt),
        .stall_err    (stall_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Lane handshakes are sampled at negedge; the transfer lands on the next posedge.
    always @(negedge clk) begin
        int  lane;
        sb_t e;
        if (rstn && (|(m_tvalid & m_tready))) begin
            lane = 0;
            for (int i = 0; i < NCH; i++) if (m_tvalid[i]) lane = i;
            lane_beats[lane]++;
            hs_cyc.push_back(cyc);
            check_eq("onehot", 64'($countones(m_tvalid)), 64'd1);
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                check_eq("lane", 64'(lane), 64'(e.lane));
                check_eq("data", 64'(m_tdata), 64'(e.data));
                check_eq("last", 64'(m_tlast), 64'(e.last));
            end
        end
    end

    task automatic drive_beat(input logic last, input int lane);
        s_tvalid = 1'b1;
        s_tdata  = seq;
        s_tlast  = last;
        sb_q.push_back('{lane: 2'(lane), last: last, data: seq});
        n_push++;
        if (last) exp_cnt[lane]++;
        seq++;
    endtask

    task automatic wait_hs();
        int  t;
        bit  done;
        t = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (s_tready) done = 1;
            else if (++t > HS_BUDGET) begin
                check_eq("hs_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic last, input int lane);
        drive_beat(last, lane);
        wait_hs();
    endtask

    task automatic send_pkt(input int nbeats, input int lane);
        for (int b = 0; b < nbeats; b++) send_beat(b == nbeats - 1, lane);
    endtask

    task automatic hold_check(input string tag, input int ncyc);
        bit bad;
        bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (s_tready || (m_tvalid != '0) || busy) bad = 1;
        end
        check_eq(tag, 64'(bad), 64'd0);
    endtask

    task automatic check_cnts(input string tag);
        for (int i = 0; i < NCH; i++)
            check_eq(tag, 64'(pkt_cnt[i*CW +: CW]), 64'(exp_cnt[i]));
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
    endtask

    initial begin
        int base;
        int lane1_before;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lane1_before;
        for (int i = 0; i < NCH; i++) begin
            exp_cnt[i] = 0;
            lane_beats[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_tready", 64'(s_tready), 64'd0);
        check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cur_ch", 64'(cur_ch), 64'd0);
        check_eq("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check_eq("rst_stall_err", 64'(stall_err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin over all lanes, back to back.
        base = hs_cyc.size();
        send_pkt(4, 0);
        send_pkt(4, 1);
        send_pkt(4, 2);
        s_tvalid = 1'b0;
        @(negedge clk);
        check_eq("rr_beats", 64'(hs_cyc.size() - base), 64'd12);
        if (hs_cyc.size() - base == 12) begin
            check_eq("rr_in_pkt", 64'(hs_cyc[base+3] - hs_cyc[base]), 64'd3);
            check_eq("rr_bubble0", 64'(hs_cyc[base+4] - hs_cyc[base+3]), 64'd2);
            check_eq("rr_bubble1", 64'(hs_cyc[base+8] - hs_cyc[base+7]), 64'd2);
        end
        check_cnts("rr_cnt");

        // Lane 1 disabled.
        pulse_clr();
        check_cnts("clr_cnt");
        cfg_ch_en = 3'b101;
        lane1_before = lane_beats[1];
        send_pkt(2, 0);
        send_pkt(2, 2);
        send_pkt(2, 0);
        send_pkt(2, 2);
        s_tvalid = 1'b0;
        @(negedge clk);
        check_eq("skip_lane1", 64'(lane_beats[1] - lane1_before), 64'd0);
        check_cnts("skip_cnt");

        // Fixed lane, then an invalid lane index, then recovery on lane 2.
        cfg_ch_en    = 3'b111;
        cfg_fixed_en = 1'b1;
        cfg_fixed_ch = 2'd1;
        for (int p = 0; p < 5; p++) send_pkt(3, 1);
        s_tvalid = 1'b0;
        @(negedge clk);
        cfg_fixed_ch = 2'd3;
        drive_beat(1'b0, 2);
        hold_check("fixed3_hold", 10);
        cfg_fixed_ch = 2'd2;
        wait_hs();
        send_beat(1'b0, 2);
        send_beat(1'b1, 2);
        s_tvalid = 1'b0;
        @(negedge clk);
        check_eq("fixed_cur_ch", 64'(cur_ch), 64'd2);
        check_cnts("fixed_cnt");

        // Enable mask cleared mid-packet; packet still completes on lane 0.
        cfg_fixed_en = 1'b0;
        send_beat(1'b0, 0);
        send_beat(1'b0, 0);
        cfg_ch_en = '0;
        for (int b = 2; b < 8; b++) send_beat(b == 7, 0);
        drive_beat(1'b1, 1);
        hold_check("noen_hold", 8);
        cfg_ch_en = 3'b111;
        wait_hs();
        s_tvalid = 1'b0;
        @(negedge clk);
        check_cnts("midcfg_cnt");

        // Stall on lane 2 for 20 cycles.
        send_beat(1'b0, 2);
        m_tready = '0;
        drive_beat(1'b0, 2);
        repeat (LIMIT - 1) @(posedge clk);
        @(negedge clk);
        check_eq("stall_before", 64'(stall_err), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("stall_set", 64'(stall_err), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        m_tready = '1;
        wait_hs();
        send_beat(1'b1, 2);
        s_tvalid = 1'b0;
        @(negedge clk);
        check_eq("stall_sticky", 64'(stall_err), 64'd1);
        check_cnts("stall_cnt");
        pulse_clr();
        check_eq("stall_clr", 64'(stall_err), 64'd0);
        check_cnts("stall_clr_cnt");

        // Reset while lane 1 is mid-packet.
        send_pkt(1, 0);
        send_beat(1'b0, 1);
        send_beat(1'b0, 1);
        s_tdata = seq;
        s_tlast = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check_eq("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("arst_s_tready", 64'(s_tready), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
        check_cnts("arst_cnt");
        s_tvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(2, 0);
        s_tvalid = 1'b0;
        @(negedge clk);
        check_cnts("post_rst_cnt");

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        check_eq("sb_popped", 64'(n_pop), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
